// File: rtl/demux_pipe_if.sv
// Handshake bundle between the demux_pipe producer, its per-channel consumers and the demux itself.
// master = the side that drives the inputs of the demux; slave = the demux.
interface demux_pipe_if #(
    parameter int bus_size  = 8,
    parameter int sel_width = 4,
    parameter int channels  = 16
);
    logic [sel_width-1:0]         select;
    logic                         broadcast;
    logic [bus_size-1:0]          in;
    logic                         in_valid;
    logic                         in_ready;
    logic [channels*bus_size-1:0] out;
    logic [channels-1:0]          out_valid;
    logic [channels-1:0]          out_ready;
    logic                         sel_err;
    logic [15:0]                  xfer_count;

    modport master (
        output select, broadcast, in, in_valid, out_ready,
        input  in_ready, out, out_valid, sel_err, xfer_count
    );

    modport slave (
        input  select, broadcast, in, in_valid, out_ready,
        output in_ready, out, out_valid, sel_err, xfer_count
    );
endinterface

// File: rtl/demux_pipe.sv
// One-deep per-channel demultiplexer: a word goes to one slot (unicast) or to every slot at once
// (broadcast), each slot holds it until its consumer takes it.
module demux_pipe #(
    parameter int bus_size  = 8,
    parameter int sel_width = 4,
    parameter int channels  = 16
) (
    input  logic        clk,
    input  logic        reset,
    demux_pipe_if.slave bus
);
    localparam logic [sel_width:0] CH_LIMIT = (sel_width + 1)'(channels);

    logic [bus_size-1:0] r_data [channels];
    logic [channels-1:0] r_valid;
    logic                r_sel_err;
    logic [15:0]         r_count;

    logic [channels-1:0] w_free;
    logic [channels-1:0] w_target;
    logic                w_sel_ok;
    logic                w_ready;
    logic                w_accept;

    // A slot is free if empty or being drained this very cycle.
    generate
        for (genvar gi = 0; gi < channels; gi++) begin : g_ch
            assign w_free[gi]   = !r_valid[gi] || bus.out_ready[gi];
            assign w_target[gi] = bus.broadcast || (bus.select == sel_width'(gi));
            assign bus.out[gi*bus_size +: bus_size] = r_data[gi];
        end
    endgenerate

    assign w_sel_ok = {1'b0, bus.select} < CH_LIMIT;
    assign w_ready  = !reset && (bus.broadcast ? (&w_free)
                                               : (w_sel_ok && |(w_target & w_free)));
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < channels; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int k = 0; k < channels; k++) begin
                if (w_accept && w_target[k]) begin
                    r_data[k]  <= bus.in;
                    r_valid[k] <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_err <= 1'b0;
            r_count   <= '0;
        end else begin
            r_sel_err <= bus.in_valid && !bus.broadcast && !w_sel_ok;
            if (w_accept && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_valid  = r_valid;
    assign bus.sel_err    = r_sel_err;
    assign bus.xfer_count = r_count;
endmodule

// File: tb/tb_demux_pipe.sv
// Drives a 16-channel and a 12-channel demux_pipe with identical stimulus and checks both
// against a slot-level model every cycle, plus literal expectations for the key scenarios.
module tb_demux_pipe;
    logic        clk;
    logic        rst;
    logic [3:0]  sel;
    logic        bc;
    logic [7:0]  din;
    logic        vld;
    logic [15:0] ordy;

    int n_cmp  = 0;
    int n_fail = 0;

    demux_pipe_if #(.bus_size(8), .sel_width(4), .channels(16)) if_a ();
    demux_pipe_if #(.bus_size(8), .sel_width(4), .channels(12)) if_b ();

    assign if_a.select    = sel;
    assign if_a.broadcast = bc;
    assign if_a.in        = din;
    assign if_a.in_valid  = vld;
    assign if_a.out_ready = ordy;
    assign if_b.select    = sel;
    assign if_b.broadcast = bc;
    assign if_b.in        = din;
    assign if_b.in_valid  = vld;
    assign if_b.out_ready = ordy[11:0];

    demux_pipe #(.bus_size(8), .sel_width(4), .channels(16)) dut_a (
        .clk(clk), .reset(rst), .bus(if_a)
    );
    demux_pipe #(.bus_size(8), .sel_width(4), .channels(12)) dut_b (
        .clk(clk), .reset(rst), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot-level model: per instance, a held word and a valid flag per channel.
    logic        m_valid [2][16];
    logic [7:0]  m_data  [2][16];
    logic [15:0] m_cnt   [2];
    logic        m_err   [2];

    function automatic int nch(input int n);
        return (n == 0) ? 16 : 12;
    endfunction

    function automatic logic exp_ready(input int n);
        if (rst) return 1'b0;
        if (bc) begin
            for (int k = 0; k < nch(n); k++)
                if (m_valid[n][k] && !ordy[k]) return 1'b0;
            return 1'b1;
        end
        if (int'(sel) >= nch(n)) return 1'b0;
        return !m_valid[n][sel] || ordy[sel];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) begin
                    m_valid[n][k] <= 1'b0;
                    m_data[n][k]  <= 8'h00;
                end
                m_cnt[n] <= 16'h0000;
                m_err[n] <= 1'b0;
            end else begin
                for (int k = 0; k < nch(n); k++) begin
                    if (vld && exp_ready(n) && (bc || int'(sel) == k)) begin
                        m_valid[n][k] <= 1'b1;
                        m_data[n][k]  <= din;
                    end else if (ordy[k]) begin
                        m_valid[n][k] <= 1'b0;
                    end
                end
                if (vld && exp_ready(n) && m_cnt[n] != 16'hFFFF)
                    m_cnt[n] <= m_cnt[n] + 16'd1;
                m_err[n] <= vld && !bc && (int'(sel) >= nch(n));
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int n, input string tag, input logic ir, input logic [127:0] out_flat,
                            input logic [15:0] ov, input logic se, input logic [15:0] cnt);
        logic [127:0] e_out;
        logic [15:0]  e_ov;
        e_out = '0;
        e_ov  = '0;
        for (int k = 0; k < nch(n); k++) begin
            e_out[k*8 +: 8] = m_data[n][k];
            e_ov[k]         = m_valid[n][k];
        end
        check({tag, ".in_ready"},   128'(ir),  128'(exp_ready(n)));
        check({tag, ".out"},        out_flat,  e_out);
        check({tag, ".out_valid"},  128'(ov),  128'(e_ov));
        check({tag, ".sel_err"},    128'(se),  128'(m_err[n]));
        check({tag, ".xfer_count"}, 128'(cnt), 128'(m_cnt[n]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, "a", if_a.in_ready, 128'(if_a.out), if_a.out_valid, if_a.sel_err, if_a.xfer_count);
        cmp_inst(1, "b", if_b.in_ready, 128'(if_b.out), 16'(if_b.out_valid), if_b.sel_err, if_b.xfer_count);
    end

    task automatic apply(input logic [3:0] s, input logic b_, input logic [7:0] d,
                         input logic v, input logic [15:0] r);
        sel = s; bc = b_; din = d; vld = v; ordy = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        apply(4'd5, 1'b0, 8'hEE, 1'b1, 16'h0000);
        repeat (3) tick();
        check("rst.in_ready",  128'(if_a.in_ready),  128'(0));
        check("rst.out_valid", 128'(if_a.out_valid), 128'(0));
        rst = 1'b0;

        // Unicast to channel 5 right after reset.
        apply(4'd5, 1'b0, 8'hA5, 1'b1, 16'h0000);
        $display("xfer: unicast sel=5 data=a5");
        tick();
        apply(4'd0, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("uni.out_valid", 128'(if_a.out_valid),  128'(16'h0020));
        check("uni.ch5",       128'(if_a.out[5*8 +: 8]), 128'(8'hA5));
        check("uni.count",     128'(if_a.xfer_count), 128'(1));
        apply(4'd0, 1'b0, 8'h00, 1'b0, 16'hFFFF);
        tick();

        // Backpressure on channel 3, independent channel 4, then drain+refill of 3.
        apply(4'd3, 1'b0, 8'h11, 1'b1, 16'h0000);
        $display("xfer: unicast sel=3 data=11");
        tick();
        apply(4'd3, 1'b0, 8'h22, 1'b1, 16'h0000);
        check("bp.blocked", 128'(if_a.in_ready), 128'(0));
        tick();
        apply(4'd4, 1'b0, 8'h44, 1'b1, 16'h0000);
        check("bp.other_ready", 128'(if_a.in_ready), 128'(1));
        $display("xfer: unicast sel=4 data=44");
        tick();
        check("bp.out_valid", 128'(if_a.out_valid), 128'(16'h0018));
        check("bp.ch3_held",  128'(if_a.out[3*8 +: 8]), 128'(8'h11));
        apply(4'd3, 1'b0, 8'h33, 1'b1, 16'h0008);
        check("bp.refill_ready", 128'(if_a.in_ready), 128'(1));
        $display("xfer: drain+refill sel=3 data=33");
        tick();
        apply(4'd0, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("bp.refill_valid", 128'(if_a.out_valid), 128'(16'h0018));
        check("bp.refill_data",  128'(if_a.out[3*8 +: 8]), 128'(8'h33));
        check("bp.count",        128'(if_a.xfer_count), 128'(4));
        apply(4'd0, 1'b0, 8'h00, 1'b0, 16'hFFFF);
        tick();

        // Broadcast into empty slots, then a blocked broadcast with channel 0 held.
        apply(4'd0, 1'b1, 8'h3C, 1'b1, 16'h0000);
        check("bc.ready", 128'(if_a.in_ready), 128'(1));
        $display("xfer: broadcast data=3c");
        tick();
        apply(4'd0, 1'b0, 8'h00, 1'b0, 16'hFFFE);
        check("bc.out_valid", 128'(if_a.out_valid), 128'(16'hFFFF));
        for (int k = 0; k < 16; k++)
            check($sformatf("bc.ch%0d", k), 128'(if_a.out[k*8 +: 8]), 128'(8'h3C));
        check("bc.count", 128'(if_a.xfer_count), 128'(5));
        tick();
        apply(4'd0, 1'b1, 8'h5A, 1'b1, 16'h0000);
        check("bc.blocked", 128'(if_a.in_ready), 128'(0));
        tick();
        check("bc.unchanged_valid", 128'(if_a.out_valid), 128'(16'h0001));
        check("bc.unchanged_ch0",   128'(if_a.out[7:0]),  128'(8'h3C));
        check("bc.unchanged_count", 128'(if_a.xfer_count), 128'(5));
        apply(4'd0, 1'b0, 8'h00, 1'b0, 16'hFFFF);
        tick();

        // Out-of-range select on the 12-channel instance for two cycles.
        apply(4'd13, 1'b0, 8'h77, 1'b1, 16'h0000);
        check("oor.ready1", 128'(if_b.in_ready), 128'(0));
        tick();
        check("oor.err1",   128'(if_b.sel_err), 128'(1));
        check("oor.ready2", 128'(if_b.in_ready), 128'(0));
        tick();
        apply(4'd13, 1'b0, 8'h77, 1'b0, 16'h0000);
        check("oor.err2",   128'(if_b.sel_err), 128'(1));
        check("oor.valid",  128'(if_b.out_valid), 128'(0));
        tick();
        check("oor.no_err_idle", 128'(if_b.sel_err), 128'(0));
        check("oor.no_ready_idle", 128'(if_b.in_ready), 128'(0));

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 2000; i++) begin
            apply(4'($urandom_range(15, 0)), ($urandom_range(7, 0) == 0),
                  8'($urandom), ($urandom_range(3, 0) != 0), 16'($urandom));
            if (vld && if_a.in_ready)
                $display("xfer: rnd %0d sel=%0d bc=%0b data=%02h", i, sel, bc, din);
            tick();
            if (i == 1000) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        // Run the counter into saturation with back-to-back unicasts.
        for (int i = 0; i < 65540; i++) begin
            apply(4'd0, 1'b0, 8'(i), 1'b1, 16'hFFFF);
            tick();
        end
        check("sat.count_a", 128'(if_a.xfer_count), 128'(16'hFFFF));
        check("sat.count_b", 128'(if_b.xfer_count), 128'(16'hFFFF));
        apply(4'd1, 1'b0, 8'h99, 1'b1, 16'hFFFF);
        check("sat.ready", 128'(if_a.in_ready), 128'(1));
        $display("xfer: saturating unicast sel=1 data=99");
        tick();
        check("sat.hold",  128'(if_a.xfer_count), 128'(16'hFFFF));
        check("sat.valid", 128'(if_a.out_valid[1]), 128'(1));

        // Reset between edges must clear everything before the next edge.
        #2 rst = 1'b1;
        #1;
        check("arst.out_valid", 128'(if_a.out_valid),  128'(0));
        check("arst.out",       128'(if_a.out),        128'(0));
        check("arst.count",     128'(if_a.xfer_count), 128'(0));
        check("arst.sel_err",   128'(if_a.sel_err),    128'(0));
        check("arst.in_ready",  128'(if_a.in_ready),   128'(0));
        check("arst.b_count",   128'(if_b.xfer_count), 128'(0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
